load_store_unit: RTL

- Executes the memory command issued by the control unit: mem_op, mem_read_type and mem_write_mask.
- Runs one transaction on the word-addressed data bus using a req/ack handshake.
- Lane-shifts store data and generates byte strobes; on loads, extracts and sign- or zero-extends the addressed bytes.
- Sits between the ALU result (effective address), the rs2 read port, and the regfile REG_SRC_MEM write path. Stalls the core while a transaction is outstanding.

---
 rtl/load_store_unit_pkg.sv | 52 +++++
 rtl/load_store_unit_load_extend.sv | 36 +++
 rtl/load_store_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings, FSM state type and lane helpers for the load/store unit.
package load_store_unit_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [2:0] MEM_RD_NONE = 3'd0;
    localparam logic [2:0] MEM_RD_BYTE = 3'd1;
    localparam logic [2:0] MEM_RD_HALF = 3'd2;
    localparam logic [2:0] MEM_RD_WORD = 3'd3;
    localparam logic [2:0] MEM_RD_B_U  = 3'd4;
    localparam logic [2:0] MEM_RD_H_U  = 3'd5;

    localparam logic [3:0] MEM_WR_NONE = 4'b0000;
    localparam logic [3:0] MEM_WR_BYTE = 4'b0001;
    localparam logic [3:0] MEM_WR_HALF = 4'b0011;
    localparam logic [3:0] MEM_WR_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Byte offset snapped to the access size: word -> 0, half -> even, byte -> as given.
    function automatic logic [1:0] natural_offset(input logic is_load, input logic [2:0] rtype,
                                                  input logic [3:0] mask, input logic [1:0] off);
        logic word;
        logic half;
        word = is_load ? (rtype == MEM_RD_WORD) : (mask == MEM_WR_WORD);
        half = is_load ? (rtype == MEM_RD_HALF || rtype == MEM_RD_H_U) : (mask == MEM_WR_HALF);
        if (word)      return 2'b00;
        else if (half) return {off[1], 1'b0};
        else           return off;
    endfunction

    function automatic logic is_misaligned(input logic is_load, input logic [2:0] rtype,
                                           input logic [3:0] mask, input logic [1:0] off);
        return natural_offset(is_load, rtype, mask, off) != off;
    endfunction

    // Replicating the datum across lanes makes the lane shift a no-op on wdata.
    function automatic logic [31:0] store_lanes(input logic [3:0] mask, input logic [31:0] data);
        case (mask)
            MEM_WR_BYTE: return {4{data[7:0]}};
            MEM_WR_HALF: return {2{data[15:0]}};
            default:     return data;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational byte/half extraction and sign/zero extension of bus read data.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  read_type,
    output logic [31:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = 8'h00;
        case (offset)
            2'd0: byte_val = rdata[7:0];
            2'd1: byte_val = rdata[15:8];
            2'd2: byte_val = rdata[23:16];
            2'd3: byte_val = rdata[31:24];
            default: byte_val = 8'h00;
        endcase
        half_val = offset[1] ? rdata[31:16] : rdata[15:0];

        data = 32'h0;
        case (read_type)
            MEM_RD_BYTE: data = {{24{byte_val[7]}}, byte_val};
            MEM_RD_HALF: data = {{16{half_val[15]}}, half_val};
            MEM_RD_WORD: data = rdata;
            MEM_RD_B_U:  data = {24'h0, byte_val};
            MEM_RD_H_U:  data = {16'h0, half_val};
            default:     data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one req/ack bus transaction per memory command, with lane steering.
// Build option LSU_MISALIGN_TRAP_EN rejects misaligned accesses instead of aligning them.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  mem_read_type,
    input  logic [3:0]  mem_write_mask,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CW-1:0] TERM = CW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    lsu_state_e  state;
    logic [CW-1:0] cnt;
    logic        lat_load;
    logic [2:0]  lat_rtype;
    logic [1:0]  lat_off;

    logic        cmd;
    logic        is_load;
    logic        trap;
    logic [1:0]  off;
    logic [31:0] ext_data;

    assign cmd     = start && (mem_op != MEM_OP_NONE);
    assign is_load = (mem_op == MEM_OP_LOAD);
    assign off     = natural_offset(is_load, mem_read_type, mem_write_mask, addr[1:0]);
    assign stall   = (state == ST_IDLE && cmd) || (state == ST_REQ);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(is_load, mem_read_type, mem_write_mask, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    load_extend u_load_extend (
        .rdata     (bus_rdata),
        .offset    (lat_off),
        .read_type (lat_rtype),
        .data      (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_load   <= 1'b0;
            lat_rtype  <= MEM_RD_NONE;
            lat_off    <= 2'b00;
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
            load_data  <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd) begin
                        if (trap) begin
                            misaligned <= 1'b1;
                        end else begin
                            state     <= ST_REQ;
                            cnt       <= '0;
                            lat_load  <= is_load;
                            lat_rtype <= mem_read_type;
                            lat_off   <= off;
                            bus_req   <= 1'b1;
                            bus_we    <= !is_load;
                            bus_addr  <= addr[31:2];
                            bus_wdata <= store_lanes(mem_write_mask, store_data);
                            bus_wstrb <= mem_write_mask << off;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack on the terminal count still completes normally.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                        if (lat_load) load_data <= ext_data;
                    end else if (BUS_TIMEOUT != 0 && cnt == TERM) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
